stepper_cmd_consumer: RTL and testbench

Reader side of the processor's memory-mapped motor-command registers. The processor writes a step count, direction and step period, then raises `cmd_valid`. This block accepts the command and emits a `step`/`dir` pulse train for one stepper axis, then reports completion. One instance exists per axis in the drawing-robot datapath.

---
 rtl/stepper_cmd_consumer_pkg.sv | 15 +
 rtl/stepper_cmd_consumer_phase_timer.sv | 31 +++
 rtl/stepper_cmd_consumer.sv | 148 ++++++++++++++
 tb/tb_stepper_cmd_consumer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_cmd_consumer_pkg.sv
// Shared definitions for the stepper command consumer.
//   state_t    : controller state encoding (IDLE/HIGH/LOW/DONE)
//   MIN_PERIOD : shortest step period in clk cycles; shorter requests are raised to it
package stepper_cmd_consumer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/stepper_cmd_consumer_phase_timer.sv
// Phase timer: W-bit down-counter with synchronous load and terminal-count flag.
//   clk        : system clock
//   clr        : synchronous active-high reset (count -> 0)
//   load       : load load_value this edge
//   load_value : phase length minus one
//   tc         : count has reached zero (last cycle of the current phase)
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/stepper_cmd_consumer.sv
// Stepper command consumer: accepts a (steps, dir, period) command and emits a
// step/dir pulse train for one axis, then pulses done.
//   clk, clr    : clock and synchronous active-high reset
//   cmd_valid   : command present on cmd_* inputs
//   cmd_ready   : command can be accepted this cycle (decoded from registers only)
//   cmd_steps   : number of steps
//   cmd_dir     : direction for the command
//   cmd_period  : clk cycles per step (values below MIN_PERIOD are raised)
//   abort       : cancel an executing command
//   step, dir   : motor driver outputs
//   busy        : command executing (HIGH or LOW phase)
//   done        : one-cycle pulse on normal completion
//   steps_left  : steps not yet completed
module stepper_cmd_consumer
    import stepper_cmd_consumer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    state_t             state_reg, state_next;
    // Holds cmd_ready low for the cycle following a clr edge, so a command
    // cannot be taken until clr has been seen low at an edge.
    logic               hold_reg;
    logic [DIV_W-1:0]   high_len_reg, low_len_reg;
    logic [CNT_W-1:0]   steps_left_reg;
    logic               step_reg, dir_reg, busy_reg, done_reg;

    logic [DIV_W-1:0]   period_clamped, high_len_new, low_len_new;
    logic               accept, decrement, kill;
    logic               timer_load, timer_tc;
    logic [DIV_W-1:0]   timer_value;

    phase_timer #(.W(DIV_W)) u_phase_timer (
        .clk        (clk),
        .clr        (clr),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    // High phase is the shorter half of odd periods; both halves are >= 1.
    always_comb begin
        period_clamped = (cmd_period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : cmd_period;
        high_len_new   = period_clamped >> 1;
        low_len_new    = period_clamped - high_len_new;
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        decrement   = 1'b0;
        kill        = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && !hold_reg) begin
                    accept      = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = high_len_new - DIV_W'(1);
                    state_next  = (cmd_steps == '0) ? ST_DONE : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    kill       = 1'b1;
                    state_next = ST_IDLE;
                end else if (timer_tc) begin
                    decrement   = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = low_len_reg - DIV_W'(1);
                    state_next  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    kill       = 1'b1;
                    state_next = ST_IDLE;
                end else if (timer_tc) begin
                    if (steps_left_reg != '0) begin
                        timer_load  = 1'b1;
                        timer_value = high_len_reg - DIV_W'(1);
                        state_next  = ST_HIGH;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= ST_IDLE;
            hold_reg       <= 1'b1;
            high_len_reg   <= '0;
            low_len_reg    <= '0;
            steps_left_reg <= '0;
            step_reg       <= 1'b0;
            dir_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= 1'b0;
            step_reg  <= (state_next == ST_HIGH);
            busy_reg  <= (state_next == ST_HIGH) || (state_next == ST_LOW);
            done_reg  <= (state_next == ST_DONE);
            if (accept) begin
                steps_left_reg <= cmd_steps;
                dir_reg        <= cmd_dir;
                high_len_reg   <= high_len_new;
                low_len_reg    <= low_len_new;
            end else if (kill) begin
                steps_left_reg <= '0;
            end else if (decrement && (steps_left_reg != '0)) begin
                steps_left_reg <= steps_left_reg - CNT_W'(1);
            end
        end
    end

    assign cmd_ready  = (state_reg == ST_IDLE) && !hold_reg;
    assign step       = step_reg;
    assign dir        = dir_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign steps_left = steps_left_reg;

endmodule

// File: tb/tb_stepper_cmd_consumer.sv
// Testbench for stepper_cmd_consumer: directed commands, per-cycle comparison
// against an arithmetic model of the pulse train, plus literal spot checks.
module tb_stepper_cmd_consumer;

    localparam int CNT_W = 16;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [DIV_W-1:0] cmd_period;
    logic             abort;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    always #5 clk = ~clk;

    stepper_cmd_consumer #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model: a command is described by (N, P, H, dir) and the number of
    // cycles t elapsed since its accept edge; outputs follow by arithmetic.
    bit          m_active = 1'b0;
    bit          m_hold   = 1'b1;
    bit          m_dir    = 1'b0;
    int unsigned m_n = 0, m_p = 2, m_h = 1;
    longint      m_t = 0;

    always @(posedge clk) begin
        bit     ready_now;
        bit     busy_now;
        longint total;
        total     = longint'(m_n) * longint'(m_p);
        ready_now = !m_active && !m_hold;
        busy_now  = m_active && (m_t >= 1) && (m_t <= total);
        if (clr) begin
            m_active = 1'b0;
            m_hold   = 1'b1;
            m_dir    = 1'b0;
        end else begin
            if (m_active) begin
                if (busy_now && abort) m_active = 1'b0;
                else if (m_t == total + 1) m_active = 1'b0;
                else m_t = m_t + 1;
            end else if (ready_now && cmd_valid) begin
                m_active = 1'b1;
                m_t      = 1;
                m_n      = cmd_steps;
                m_p      = (cmd_period < 2) ? 2 : cmd_period;
                m_h      = m_p / 2;
                m_dir    = cmd_dir;
            end
            m_hold = 1'b0;
        end
    end

    // {cmd_ready, step, dir, busy, done, steps_left}
    function automatic logic [CNT_W+4:0] model_out();
        longint total, ph, comp;
        if (!m_active)
            return {!m_hold, 1'b0, m_dir, 1'b0, 1'b0, CNT_W'(0)};
        total = longint'(m_n) * longint'(m_p);
        if (m_t <= total) begin
            ph   = (m_t - 1) % m_p;
            comp = (m_t - 1) / m_p + ((ph >= m_h) ? 1 : 0);
            return {1'b0, (ph < m_h), m_dir, 1'b1, 1'b0, CNT_W'(longint'(m_n) - comp)};
        end
        return {1'b0, 1'b0, m_dir, 1'b0, 1'b1, CNT_W'(0)};
    endfunction

    always @(negedge clk) begin
        logic [CNT_W+4:0] got, exp;
        if (chk_en) begin
            got = {cmd_ready, step, dir, busy, done, steps_left};
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL per_cycle t=%0t got={rdy,stp,dir,bsy,dn,left}=%h required=%h",
                         $time, got, exp);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h required=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called mid-cycle 0; returns mid-cycle 1 with cmd_valid dropped.
    task automatic send(input int unsigned n, input bit d, input int unsigned p);
        lit("ready_at_accept", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_steps  = CNT_W'(n);
        cmd_dir    = d;
        cmd_period = DIV_W'(p);
        @(negedge clk);
        cyc       = 1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        clr = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
        cmd_period = '0; abort = 1'b0;

        // 1: reset held two edges, then released
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        lit("ready_during_clr", 32'(cmd_ready), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        lit("reset_ready", 32'(cmd_ready), 32'd1);
        lit("reset_outs", {28'd0, step, dir, busy, done}, 32'd0);
        lit("reset_left", 32'(steps_left), 32'd0);

        // 2: N=3, dir=1, P=4
        cyc = 0;
        send(3, 1'b1, 4);
        lit("t2_step_c1", 32'(step), 32'd1);
        lit("t2_dir_c1", 32'(dir), 32'd1);
        run_to(3);  lit("t2_step_c3", 32'(step), 32'd0);
        lit("t2_left_c3", 32'(steps_left), 32'd2);
        run_to(6);  lit("t2_step_c6", 32'(step), 32'd1);
        run_to(11); lit("t2_left_c11", 32'(steps_left), 32'd0);
        run_to(12); lit("t2_done_c12", 32'(done), 32'd0);
        run_to(13); lit("t2_done_c13", 32'(done), 32'd1);
        lit("t2_ready_c13", 32'(cmd_ready), 32'd0);
        abort = 1'b1;  // ignored in DONE
        run_to(14); abort = 1'b0;
        lit("t2_ready_c14", 32'(cmd_ready), 32'd1);

        // 3: period 0 clamps to 2, then P=5 (H=2, L=3)
        cyc = 0;
        send(2, 1'b0, 0);
        lit("t3_step_c1", 32'(step), 32'd1);
        run_to(2); lit("t3_step_c2", 32'(step), 32'd0);
        run_to(3); lit("t3_step_c3", 32'(step), 32'd1);
        run_to(5); lit("t3_done_c5", 32'(done), 32'd1);
        run_to(6);
        cyc = 0;
        send(1, 1'b1, 5);
        run_to(2); lit("t3b_step_c2", 32'(step), 32'd1);
        run_to(3); lit("t3b_step_c3", 32'(step), 32'd0);
        run_to(5); lit("t3b_busy_c5", 32'(busy), 32'd1);
        run_to(6); lit("t3b_done_c6", 32'(done), 32'd1);
        run_to(7);

        // 4: zero steps
        cyc = 0;
        send(0, 1'b0, 7);
        lit("t4_done_c1", 32'(done), 32'd1);
        lit("t4_ready_c1", 32'(cmd_ready), 32'd0);
        lit("t4_step_c1", 32'(step), 32'd0);
        run_to(2); lit("t4_ready_c2", 32'(cmd_ready), 32'd1);

        // 5: abort mid-command, then accept with abort still high
        cyc = 0;
        send(10, 1'b1, 4);
        run_to(6); abort = 1'b1;
        run_to(7);
        lit("t5_step_c7", 32'(step), 32'd0);
        lit("t5_left_c7", 32'(steps_left), 32'd0);
        lit("t5_done_c7", 32'(done), 32'd0);
        cyc = 0;
        send(1, 1'b0, 3);
        abort = 1'b0;
        lit("t5b_step_c1", 32'(step), 32'd1);
        run_to(4); lit("t5b_done_c4", 32'(done), 32'd1);
        run_to(5);

        // 6: clr mid-command with cmd_valid held high
        cyc = 0;
        send(5, 1'b1, 4);
        run_to(3);
        clr = 1'b1; cmd_valid = 1'b1; cmd_steps = 16'd2; cmd_dir = 1'b0; cmd_period = 16'd2;
        run_to(4); clr = 1'b0;
        lit("t6_outs_c4", {28'd0, cmd_ready, step, busy, done}, 32'd0);
        lit("t6_left_c4", 32'(steps_left), 32'd0);
        run_to(5); lit("t6_ready_c5", 32'(cmd_ready), 32'd1);
        run_to(6); cmd_valid = 1'b0;
        lit("t6_step_c6", 32'(step), 32'd1);
        lit("t6_left_c6", 32'(steps_left), 32'd2);
        run_to(10); lit("t6_done_c10", 32'(done), 32'd1);
        run_to(11);

        // 7: maximum period, H = 32767, abort in LOW
        cyc = 0;
        send(2, 1'b1, 32'hFFFF);
        run_to(32767); lit("t7_step_last_high", 32'(step), 32'd1);
        run_to(32768); lit("t7_step_first_low", 32'(step), 32'd0);
        lit("t7_left", 32'(steps_left), 32'd1);
        run_to(32770); abort = 1'b1;
        run_to(32771); abort = 1'b0;
        lit("t7_abort_left", 32'(steps_left), 32'd0);
        lit("t7_abort_ready", 32'(cmd_ready), 32'd1);
        run_to(32773);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
